// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave command front end.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    SEND      = 3'd5
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int ADDR_SIZE_DFLT = 8;
  localparam int CMD_W          = ADDR_SIZE_DFLT + 2;

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load, MSB-first serializer for RAM read data returned on MISO.
module spi_tx_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         sout,
  output logic         done
);

  logic [W-1:0] shift_reg;
  logic [3:0]   cnt_reg;
  logic         done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      cnt_reg   <= 4'd0;
      done_reg  <= 1'b0;
    end else if (clr) begin
      shift_reg <= '0;
      cnt_reg   <= 4'd0;
      done_reg  <= 1'b0;
    end else if (load) begin
      shift_reg <= din;
      cnt_reg   <= 4'(W);
      done_reg  <= 1'b0;
    end else if (cnt_reg != 4'd0) begin
      // The MSB is already on the line during the load cycle, so the last shift retires bit 0.
      shift_reg <= {shift_reg[W-2:0], 1'b0};
      cnt_reg   <= cnt_reg - 4'd1;
      if (cnt_reg == 4'd1) done_reg <= 1'b1;
    end
  end

  assign sout = shift_reg[W-1] & ~done_reg;
  assign done = done_reg;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave sequencer: deserialises command frames for the RAM and returns read data on MISO.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ss_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int CW = ADDR_SIZE + 2;
  localparam logic [3:0] LAST_BIT   = 4'(CW - 2);
  localparam logic [3:0] WORD_DONE  = 4'(CW - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   rx_shift_reg, rx_shift_next;
  logic [3:0]      rx_cnt_reg, rx_cnt_next;
  logic [CW-1:0]   rx_data_reg, rx_data_next;
  logic            rx_valid_reg, rx_valid_next;
  logic            rd_addr_seen_reg, rd_addr_seen_next;
  logic            ser_load;
  logic            ser_bit;
  logic            ser_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      rx_shift_reg     <= '0;
      rx_cnt_reg       <= 4'd0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rd_addr_seen_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rx_shift_reg     <= rx_shift_next;
      rx_cnt_reg       <= rx_cnt_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      rd_addr_seen_reg <= rd_addr_seen_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    rx_shift_next     = rx_shift_reg;
    rx_cnt_next       = rx_cnt_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    rd_addr_seen_next = rd_addr_seen_reg;
    ser_load          = 1'b0;

    if (ss_n) begin
      state_next  = IDLE;
      rx_cnt_next = 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next  = CHK_CMD;
          rx_cnt_next = 4'd0;
        end
        CHK_CMD: begin
          rx_shift_next = {rx_shift_reg[CW-2:0], mosi};
          rx_cnt_next   = 4'd0;
          if (!mosi)                 state_next = WRITE;
          else if (rd_addr_seen_reg) state_next = READ_DATA;
          else                       state_next = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          // rx_cnt_reg parks at WORD_DONE once the word is delivered, marking the hold phase.
          if (rx_cnt_reg != WORD_DONE) begin
            rx_shift_next = {rx_shift_reg[CW-2:0], mosi};
            rx_cnt_next   = rx_cnt_reg + 4'd1;
            if (rx_cnt_reg == LAST_BIT) begin
              rx_data_next  = {rx_shift_reg[CW-2:0], mosi};
              rx_valid_next = 1'b1;
              if (state_reg == READ_ADD)  rd_addr_seen_next = 1'b1;
              if (state_reg == READ_DATA) rd_addr_seen_next = 1'b0;
            end
          end else if (state_reg == READ_DATA && tx_valid) begin
            ser_load   = 1'b1;
            state_next = SEND;
          end
        end
        SEND: begin
          state_next = SEND;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  spi_tx_serializer #(
    .W(ADDR_SIZE)
  ) u_tx_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ss_n),
    .load  (ser_load),
    .din   (tx_data),
    .sout  (ser_bit),
    .done  (ser_done)
  );

  assign miso     = (state_reg == SEND) & ~ser_done & ser_bit;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed, table-driven bench for spi_slave_ctrl with hand sequences for read and reset cases.
module tb_spi_slave_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;

  spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] word;
    int         nbits;
    logic       txv;
    int         exp_cnt;
    logic [9:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame starting from IDLE; raises ss_n after nbits bits when nbits < 10.
  // Observation index k means "just after the k-th rising edge since ss_n low was sampled".
  task automatic send_frame(input logic [9:0] w, input int nbits,
                            output int vcnt, output int vat,
                            output logic [9:0] vdata, output int ones);
    vcnt = 0; vat = -1; vdata = '0; ones = 0;
    ss_n = 1'b0;
    mosi = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      if (rx_valid) begin vcnt++; vat = k; vdata = rx_data; end
      if (miso) ones++;
      if (k < nbits) mosi = w[9-k];
      else begin
        mosi = 1'b0;
        if (nbits < 10 && k == nbits) ss_n = 1'b1;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    ss_n = 1'b1;
    mosi = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_miso", 32'(miso), 32'd0);
      check("idle_rx_valid", 32'(rx_valid), 32'd0);
    end
  endtask

  int         vcnt, vat, ones;
  logic [9:0] vdata;
  logic [7:0] rd_byte;

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;

    vecs[0] = '{word: 10'h014, nbits: 10, txv: 1'b0, exp_cnt: 1, exp_data: 10'h014};
    vecs[1] = '{word: 10'h1AA, nbits: 10, txv: 1'b1, exp_cnt: 1, exp_data: 10'h1AA};
    vecs[2] = '{word: 10'h0FF, nbits: 5,  txv: 1'b0, exp_cnt: 0, exp_data: 10'h000};
    vecs[3] = '{word: 10'h155, nbits: 10, txv: 1'b0, exp_cnt: 1, exp_data: 10'h155};
    vecs[4] = '{word: 10'h0F3, nbits: 9,  txv: 1'b0, exp_cnt: 0, exp_data: 10'h000};
    vecs[5] = '{word: 10'h2C3, nbits: 10, txv: 1'b1, exp_cnt: 1, exp_data: 10'h2C3};
    vecs[6] = '{word: 10'h3E1, nbits: 10, txv: 1'b0, exp_cnt: 1, exp_data: 10'h3E1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Table: write, stray tx_valid during WRITE/READ_ADD, aborts, read-address, read-data w/o response.
    for (int v = 0; v < 7; v++) begin
      tx_valid = vecs[v].txv;
      tx_data  = 8'hFF;
      send_frame(vecs[v].word, vecs[v].nbits, vcnt, vat, vdata, ones);
      $display("vec %0d word=%03h bits=%0d: rx_valid x%0d at %0d data=%03h miso_ones=%0d",
               v, vecs[v].word, vecs[v].nbits, vcnt, vat, vdata, ones);
      check($sformatf("vec%0d_valid_count", v), 32'(vcnt), 32'(vecs[v].exp_cnt));
      check($sformatf("vec%0d_miso_quiet", v), 32'(ones), 32'd0);
      if (vecs[v].exp_cnt == 1) begin
        check($sformatf("vec%0d_valid_cycle", v), 32'(vat), 32'd10);
        check($sformatf("vec%0d_rx_data", v), 32'(vdata), 32'(vecs[v].exp_data));
      end
      tx_valid = 1'b0;
      idle_cycles(2);
    end

    // Read sequence: address frame, then data frame answered on MISO.
    send_frame(10'h214, 10, vcnt, vat, vdata, ones);
    $display("rd_addr frame: rx_valid x%0d data=%03h", vcnt, vdata);
    check("rd_addr_data", 32'(vdata), 32'h214);
    idle_cycles(2);
    send_frame(10'h300, 10, vcnt, vat, vdata, ones);
    $display("rd_data frame: rx_valid x%0d data=%03h", vcnt, vdata);
    check("rd_data_data", 32'(vdata), 32'h300);
    rd_byte  = 8'hAA;
    tx_data  = rd_byte;
    tx_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      tx_data = ~rd_byte;
      $display("send cycle T+%0d: miso=%0d", j + 1, miso);
      if (j < 8) check($sformatf("send_bit%0d", 7 - j), 32'(miso), 32'(rd_byte[7-j]));
      else       check("send_tail_zero", 32'(miso), 32'd0);
    end
    tx_valid = 1'b0;
    idle_cycles(2);

    // rd_addr_seen cleared: a 1-prefixed frame must be a read address, so tx_valid does nothing.
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_frame(10'h2A5, 10, vcnt, vat, vdata, ones);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (miso) ones++;
    end
    $display("post-read frame: data=%03h miso_ones=%0d", vdata, ones);
    check("seen_cleared_route", 32'(ones), 32'd0);
    check("seen_cleared_data", 32'(vdata), 32'h2A5);
    tx_valid = 1'b0;
    idle_cycles(2);

    // Reset during SEND (rd_addr_seen is set by the previous frame).
    send_frame(10'h3C0, 10, vcnt, vat, vdata, ones);
    check("rst_pre_data", 32'(vdata), 32'h3C0);
    tx_data = 8'hFF; tx_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check("rst_pre_send_bit", 32'(miso), 32'd1);
    end
    tx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    $display("reset mid-send: miso=%0d rx_data=%03h", miso, rx_data);
    check("rst_miso_immediate", 32'(miso), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_frame(10'h3C3, 10, vcnt, vat, vdata, ones);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      if (miso) ones++;
    end
    $display("post-reset frame: data=%03h miso_ones=%0d", vdata, ones);
    check("rst_route_read_addr", 32'(ones), 32'd0);
    check("rst_post_data", 32'(vdata), 32'h3C3);
    tx_valid = 1'b0;
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI-slave front end and sequencer for the single-port command RAM. It deserialises MOSI frames into 10-bit command words, delivers them to the RAM with a one-cycle `rx_valid` strobe, and serialises read data back on MISO. It also tracks whether a read address has been loaded, so a `1`-prefixed frame is routed correctly as either read-address or read-data.

## Interface
- `ADDR_SIZE`, default 8: RAM word/address width. The command word is `ADDR_SIZE+2` bits.
- `clk`  in  1  system clock. SPI bits are sampled on rising edges, one bit per cycle.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ss_n`  in  1  slave select, active-low, frame delimiter.
- `mosi`  in  1  serial data from master, MSB first.
- `miso`  out  1  serial read data to master, MSB first.
- `rx_data`  out  ADDR_SIZE+2  command word to RAM: `[9:8]` = opcode, `[7:0]` = address/data.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_data`  in  ADDR_SIZE  read data from RAM.
- `tx_valid`  in  1  read data valid. Level or pulse is accepted.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, SEND. The state encoding is 3 bits.
- Internal flag `rd_addr_seen`: set when a READ_ADD frame completes; cleared when a READ_DATA frame completes.
- IDLE: when `ss_n`=0 is sampled, go to CHK_CMD.
- CHK_CMD: sample `mosi` as bit 9 and shift it in.
  - Bit 9 = 0: go to WRITE.
  - Bit 9 = 1 and `rd_addr_seen`=0: go to READ_ADD.
  - Bit 9 = 1 and `rd_addr_seen`=1: go to READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in bits 8..0 over 9 cycles, counted with a 4-bit counter.
  - After bit 0, register `rx_data` and pulse `rx_valid` for exactly one cycle.
  - WRITE and READ_ADD then hold until `ss_n`=1.
  - READ_DATA then waits for `tx_valid`.
- In READ_DATA, after the `rx_valid` strobe: on the first cycle with `tx_valid`=1, capture `tx_data` into the TX shift register and go to SEND. Later `tx_valid` activity is ignored until the next READ_DATA frame.
- SEND: drive 8 bits on `miso`, MSB first, one per cycle. Then `miso`=0 and hold until `ss_n`=1.
- The opcode bits `[9:8]` are forwarded unchanged. The RAM decodes them; this block does not check bit 8 against the chosen state.

## Timing
- Reset values:
  - `miso`=0, `rx_valid`=0, `rx_data`=0.
  - State = IDLE, `rd_addr_seen`=0, counters=0.
- `ss_n`=1 sampled in any state: go to IDLE next cycle. Any partial word is discarded with no `rx_valid`; `rd_addr_seen` is unchanged; `miso`=0.
- Frame latency: `ss_n` low seen at cycle 0.
  - Bit 9 is sampled at cycle 1 and bit 0 at cycle 10.
  - `rx_valid`=1 in cycle 11 only.
- Read latency: `tx_valid` seen at cycle T puts `tx_data[7]` on `miso` at T+1 and `tx_data[0]` at T+8. `miso`=0 from T+9.
- `miso`=0 in every state except SEND.
- No `rx_valid` is issued while `ss_n`=1. A `tx_valid` arriving outside the READ_DATA wait window is ignored.
- `ss_n` rising in the same cycle as the last data bit: abort; no `rx_valid`.
- Reset mid-frame: immediate return to the reset state, including `rd_addr_seen`=0.

## Structure
- Package `spi_pkg` holds:
  - the state enum;
  - opcode constants: `OP_WR_ADDR`=00, `OP_WR_DATA`=01, `OP_RD_ADDR`=10, `OP_RD_DATA`=11;
  - `CMD_W = ADDR_SIZE+2`.
- One sub-module, `spi_tx_serializer`: parallel load, 8-bit MSB-first shift, 4-bit bit counter, `done` flag.
- The top level contains the FSM, the RX shift register, the RX counter and `rd_addr_seen`.

## Test plan
- Write-address frame: `ss_n` low, MOSI 00_0001_0100. Required: `rx_valid` pulses once in cycle 11 with `rx_data`=0x014; `miso` stays 0.
- Write-data frame: MOSI 01_1010_1010. Required: `rx_data`=0x1AA; state returns to IDLE after `ss_n` high.
- Read sequence:
  - Frame 10_0001_0100 gives `rx_data`=0x214 and sets `rd_addr_seen`.
  - Frame 11_xxxx_xxxx is routed to READ_DATA.
  - With `tx_valid` and `tx_data`=0xAA driven, `miso` shows 1,0,1,0,1,0,1,0 on T+1..T+8, and `rd_addr_seen` is cleared.
- Abort: raise `ss_n` after 5 bits. Required: no `rx_valid`, return to IDLE, and the next full frame decodes correctly.
- Reset mid-SEND: assert `rst_n`=0 at T+4. Required: `miso`=0 immediately; after release, a `1`-prefixed frame routes to READ_ADD.
- Stray `tx_valid` while in WRITE: ignored, with `miso` staying 0.
